regfile_scoreboard: RTL and testbench

//  Per-register pending-write scoreboard that sequences access to the integer register file.

---
 rtl/regfile_scoreboard_pkg.sv | 15 +
 rtl/sb_counter.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 80 ++++++++
 tb/tb_regfile_scoreboard.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-address constants and a small release-decode helper for the
// integer register-file scoreboard.
package regfile_scoreboard_pkg;

  localparam int                    REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0     = 5'd0;

  // One write port hitting a given architectural register; x0 never counts.
  function automatic logic port_hit(input logic                  en,
                                    input logic [REG_ADDR_W-1:0] port_reg,
                                    input logic [REG_ADDR_W-1:0] idx);
    return en && (port_reg == idx) && (idx != REG_X0);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One register's outstanding-write counter: saturating increment on reserve,
// up to two decrements per cycle from the write ports, clamped at zero.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec0,
  input  logic             dec1,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic signed [CNT_W:0] nxt;

  // A same-cycle release frees a slot, so the reserve may land.
  assign full = (cnt == CNT_MAX) && !dec0 && !dec1;

  always_comb begin
    nxt = $signed({1'b0, cnt})
        + $signed({{CNT_W{1'b0}}, inc && !full})
        - $signed({{CNT_W{1'b0}}, dec0})
        - $signed({{CNT_W{1'b0}}, dec1});
  end

  // Flush discards everything in flight, including what would be a protocol error.
  assign ovf = !clr && inc && full;
  assign unf = !clr && nxt[CNT_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (nxt[CNT_W])  cnt <= '0;
    else                  cnt <= nxt[CNT_W-1:0];
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the integer register file: decode reserves rd,
// the mem/wb write ports release it, and decode stalls on rs1/rs2/rd status.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_valid,
  output logic                  rs2_valid,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reserve,
  output logic                  rd_full,
  input  logic [REG_ADDR_W-1:0] rel0_reg,
  input  logic                  rel0_en,
  input  logic [REG_ADDR_W-1:0] rel1_reg,
  input  logic                  rel1_en,
  input  logic                  flush,
  output logic [NREGS-1:0]      pending,
  output logic                  busy,
  output logic                  err
);

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            full;
  logic [NREGS-1:0]            ovf;
  logic [NREGS-1:0]            unf;

  assign cnt[0]  = '0;
  assign full[0] = 1'b0;
  assign ovf[0]  = 1'b0;
  assign unf[0]  = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_cnt
    localparam logic [REG_ADDR_W-1:0] IDX = REG_ADDR_W'(i);
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (reserve && (rd == IDX)),
      .dec0    (port_hit(rel0_en, rel0_reg, IDX)),
      .dec1    (port_hit(rel1_en, rel1_reg, IDX)),
      .clr     (flush),
      .cnt     (cnt[i]),
      .full    (full[i]),
      .ovf     (ovf[i]),
      .unf     (unf[i])
    );
  end

  always_comb begin
    pending = '0;
    for (int i = 1; i < NREGS; i++) pending[i] = |cnt[i];
  end

  assign busy = |pending;

  // Releases landing this cycle are bypassed by the regfile, so a source whose
  // remaining writers all retire now is already readable.
  logic [CNT_W:0] hits1, hits2;

  assign hits1 = (CNT_W+1)'(port_hit(rel0_en, rel0_reg, rs1))
               + (CNT_W+1)'(port_hit(rel1_en, rel1_reg, rs1));
  assign hits2 = (CNT_W+1)'(port_hit(rel0_en, rel0_reg, rs2))
               + (CNT_W+1)'(port_hit(rel1_en, rel1_reg, rs2));

  assign rs1_valid = (rs1 == REG_X0) || (cnt[rs1] == '0) || ({1'b0, cnt[rs1]} == hits1);
  assign rs2_valid = (rs2 == REG_X0) || (cnt[rs2] == '0) || ({1'b0, cnt[rs2]} == hits2);

  assign rd_full = (rd != REG_X0) && full[rd];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           err <= 1'b0;
    else if (|{ovf, unf})   err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a short
// randomized run; registered results are checked via an expected-value queue.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rs1, rs2, rd, rel0_reg, rel1_reg;
  logic        rs1_valid, rs2_valid, rd_full;
  logic        reserve, rel0_en, rel1_en, flush;
  logic [31:0] pending;
  logic        busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pend;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  regfile_scoreboard #(.NREGS(32), .CNT_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_valid (rs1_valid),
    .rs2_valid (rs2_valid),
    .rd        (rd),
    .reserve   (reserve),
    .rd_full   (rd_full),
    .rel0_reg  (rel0_reg),
    .rel0_en   (rel0_en),
    .rel1_reg  (rel1_reg),
    .rel1_en   (rel1_en),
    .flush     (flush),
    .pending   (pending),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    reserve = 0; rel0_en = 0; rel1_en = 0; flush = 0;
    rd = 0; rel0_reg = 0; rel1_reg = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic do_reset;
    idle();
    reset_n = 0;
    #2;
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset;
    idle();
    reset_n = 0;
    repeat (2) tick();
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got %h want %h", pending, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    reset_n = 1;
    tick();
    rd = 5; reserve = 1;
    tick(); tick();
    reserve = 0;
    #1;
    n_checks++; if (pending !== 32'h20) begin n_fail++; $display("FAIL pre_reset_pending got %h want %h", pending, 32'h20); end
    #2 reset_n = 0;
    #1;
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL async_reset_pending got %h want 0", pending); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got %b want 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL async_reset_err got %b want 0", err); end
    rs1 = 5;
    #1;
    n_checks++; if (rs1_valid !== 1'b1) begin n_fail++; $display("FAIL async_reset_rs1_valid got %b want 1", rs1_valid); end
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_raw;
    do_reset();
    rd = 3; reserve = 1; rs1 = 3; rs2 = 3;
    exp_q.push_back('{pend: 32'h8, err: 1'b0});
    tick();
    reserve = 0;
    #1;
    e = exp_q.pop_front();
    n_checks++; if (pending !== e.pend) begin n_fail++; $display("FAIL raw_pending_c1 got %h want %h", pending, e.pend); end
    n_checks++; if (rs1_valid !== 1'b0) begin n_fail++; $display("FAIL raw_rs1_valid_c1 got %b want 0", rs1_valid); end
    n_checks++; if (rs2_valid !== 1'b0) begin n_fail++; $display("FAIL raw_rs2_valid_c1 got %b want 0", rs2_valid); end
    tick();
    rel1_en = 1; rel1_reg = 3;
    #1;
    n_checks++; if (rs1_valid !== 1'b1) begin n_fail++; $display("FAIL raw_rs1_writethrough got %b want 1", rs1_valid); end
    n_checks++; if (rs2_valid !== 1'b1) begin n_fail++; $display("FAIL raw_rs2_writethrough got %b want 1", rs2_valid); end
    exp_q.push_back('{pend: 32'h0, err: 1'b0});
    tick();
    rel1_en = 0;
    e = exp_q.pop_front();
    n_checks++; if (pending !== e.pend) begin n_fail++; $display("FAIL raw_pending_c3 got %h want %h", pending, e.pend); end
    n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL raw_err got %b want %b", err, e.err); end
  endtask

  task automatic test_saturation;
    do_reset();
    rd = 7; reserve = 1;
    repeat (3) tick();
    reserve = 0;
    #1;
    n_checks++; if (rd_full !== 1'b1) begin n_fail++; $display("FAIL sat_rd_full got %b want 1", rd_full); end
    n_checks++; if (pending !== 32'h80) begin n_fail++; $display("FAIL sat_pending got %h want %h", pending, 32'h80); end
    reserve = 1;
    exp_q.push_back('{pend: 32'h80, err: 1'b1});
    tick();
    reserve = 0;
    e = exp_q.pop_front();
    n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL sat_overflow_err got %b want %b", err, e.err); end
    n_checks++; if (pending !== e.pend) begin n_fail++; $display("FAIL sat_overflow_pending got %h want %h", pending, e.pend); end
    #1;
    n_checks++; if (rd_full !== 1'b1) begin n_fail++; $display("FAIL sat_hold_full got %b want 1", rd_full); end
    rel0_en = 1; rel0_reg = 7; rel1_en = 1; rel1_reg = 7;
    #1;
    n_checks++; if (rd_full !== 1'b0) begin n_fail++; $display("FAIL sat_full_with_release got %b want 0", rd_full); end
    exp_q.push_back('{pend: 32'h80, err: 1'b1});
    tick();
    rel0_en = 0; rel1_en = 0;
    e = exp_q.pop_front();
    n_checks++; if (pending !== e.pend) begin n_fail++; $display("FAIL sat_dual_release_pending got %h want %h", pending, e.pend); end
    #1;
    n_checks++; if (rd_full !== 1'b0) begin n_fail++; $display("FAIL sat_cnt1_full got %b want 0", rd_full); end
    rel0_en = 1; rel0_reg = 7; rs1 = 7;
    #1;
    n_checks++; if (rs1_valid !== 1'b1) begin n_fail++; $display("FAIL sat_last_release_valid got %b want 1", rs1_valid); end
    exp_q.push_back('{pend: 32'h0, err: 1'b1});
    tick();
    rel0_en = 0;
    e = exp_q.pop_front();
    n_checks++; if (pending !== e.pend) begin n_fail++; $display("FAIL sat_drained_pending got %h want %h", pending, e.pend); end
    n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL sat_err_sticky got %b want %b", err, e.err); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    rd = 9; reserve = 1;
    tick();
    rel0_en = 1; rel0_reg = 9; rs1 = 9;
    #1;
    n_checks++; if (rs1_valid !== 1'b1) begin n_fail++; $display("FAIL simul_rs1_same_cycle got %b want 1", rs1_valid); end
    exp_q.push_back('{pend: 32'h200, err: 1'b0});
    tick();
    idle(); rs1 = 9;
    #1;
    n_checks++; if (rs1_valid !== 1'b0) begin n_fail++; $display("FAIL simul_rs1_next got %b want 0", rs1_valid); end
    e = exp_q.pop_front();
    n_checks++; if (pending !== e.pend) begin n_fail++; $display("FAIL simul_pending got %h want %h", pending, e.pend); end
    n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL simul_err got %b want %b", err, e.err); end
    rel0_en = 1; rel0_reg = 9;
    exp_q.push_back('{pend: 32'h0, err: 1'b0});
    tick();
    rel0_en = 0;
    e = exp_q.pop_front();
    n_checks++; if (pending !== e.pend || err !== e.err) begin n_fail++; $display("FAIL simul_cnt_was_1 got %h/%b want %h/%b", pending, err, e.pend, e.err); end
  endtask

  task automatic test_x0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rd = 0; reserve = 1; rel0_en = 1; rel0_reg = 0; rel1_en = (k % 2 == 0); rel1_reg = 0;
      rs1 = 0; rs2 = 0;
      #1;
      n_checks++; if (rd_full !== 1'b0) begin n_fail++; $display("FAIL x0_rd_full[%0d] got %b want 0", k, rd_full); end
      n_checks++; if (rs1_valid !== 1'b1 || rs2_valid !== 1'b1) begin n_fail++; $display("FAIL x0_rs_valid[%0d] got %b%b want 11", k, rs1_valid, rs2_valid); end
      exp_q.push_back('{pend: 32'h0, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      n_checks++; if (pending !== e.pend || err !== e.err) begin n_fail++; $display("FAIL x0_state[%0d] got %h/%b want %h/%b", k, pending, err, e.pend, e.err); end
    end
    idle();
  endtask

  task automatic test_flush;
    do_reset();
    rd = 4; reserve = 1;
    tick(); tick();
    rd = 12;
    tick();
    reserve = 0;
    #1;
    n_checks++; if (pending !== 32'h1010) begin n_fail++; $display("FAIL flush_pre_pending got %h want %h", pending, 32'h1010); end
    flush = 1; reserve = 1; rd = 4;
    exp_q.push_back('{pend: 32'h0, err: 1'b0});
    tick();
    idle();
    e = exp_q.pop_front();
    n_checks++; if (pending !== e.pend) begin n_fail++; $display("FAIL flush_pending got %h want %h", pending, e.pend); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
    n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL flush_err got %b want %b", err, e.err); end
    rel0_en = 1; rel0_reg = 12;
    exp_q.push_back('{pend: 32'h0, err: 1'b1});
    tick();
    idle();
    e = exp_q.pop_front();
    n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL flush_late_release_err got %b want %b", err, e.err); end
    n_checks++; if (pending !== e.pend) begin n_fail++; $display("FAIL flush_late_release_pending got %h want %h", pending, e.pend); end
  endtask

  // Reference behaviour for the randomized run, derived from the counter equations.
  int m_cnt[32];
  bit m_err;

  function automatic int rel_hits(input logic [4:0] r);
    int h = 0;
    if (r != 0 && rel0_en && rel0_reg == r) h++;
    if (r != 0 && rel1_en && rel1_reg == r) h++;
    return h;
  endfunction

  function automatic logic exp_src_ok(input logic [4:0] r);
    return (r == 0) || (m_cnt[r] == 0) || (m_cnt[r] == rel_hits(r));
  endfunction

  task automatic test_random;
    logic        full_m;
    logic [31:0] pend_m;
    for (int c = 0; c < 400; c++) begin
      if (c % 80 == 0) begin
        do_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 0;
      end
      reserve  = ($urandom_range(0, 1) == 1);
      rd       = 5'($urandom_range(0, 5));
      rel0_en  = ($urandom_range(0, 2) == 0);
      rel0_reg = 5'($urandom_range(0, 5));
      rel1_en  = ($urandom_range(0, 2) == 0);
      rel1_reg = 5'($urandom_range(0, 5));
      flush    = ($urandom_range(0, 24) == 0);
      rs1      = 5'($urandom_range(0, 5));
      rs2      = 5'($urandom_range(0, 5));
      #1;
      full_m = (rd != 0) && (m_cnt[rd] == 3) && (rel_hits(rd) == 0);
      n_checks++; if (rd_full !== full_m) begin n_fail++; $display("FAIL rand_rd_full[%0d] got %b want %b", c, rd_full, full_m); end
      n_checks++; if (rs1_valid !== exp_src_ok(rs1)) begin n_fail++; $display("FAIL rand_rs1_valid[%0d] got %b want %b", c, rs1_valid, exp_src_ok(rs1)); end
      n_checks++; if (rs2_valid !== exp_src_ok(rs2)) begin n_fail++; $display("FAIL rand_rs2_valid[%0d] got %b want %b", c, rs2_valid, exp_src_ok(rs2)); end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else begin
        if (reserve && full_m) m_err = 1;
        for (int i = 1; i < 32; i++) begin
          int n;
          n = m_cnt[i];
          if (reserve && rd == 5'(i) && !full_m) n++;
          n -= rel_hits(5'(i));
          if (n < 0) begin n = 0; m_err = 1; end
          m_cnt[i] = n;
        end
      end
      pend_m = '0;
      for (int i = 1; i < 32; i++) pend_m[i] = (m_cnt[i] != 0);
      exp_q.push_back('{pend: pend_m, err: m_err});
      tick();
      e = exp_q.pop_front();
      n_checks++; if (pending !== e.pend) begin n_fail++; $display("FAIL rand_pending[%0d] got %h want %h", c, pending, e.pend); end
      n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL rand_err[%0d] got %b want %b", c, err, e.err); end
      n_checks++; if (busy !== (e.pend != 0)) begin n_fail++; $display("FAIL rand_busy[%0d] got %b want %b", c, busy, (e.pend != 0)); end
    end
    idle();
  endtask

  initial begin
    idle();
    reset_n = 0;
    test_reset();
    test_raw();
    test_saturation();
    test_simultaneous();
    test_x0();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
